// File: rtl/prog_sequencer_if.sv
// Bundle of the prog_sequencer control and status signals.
//   slave  : the sequencer side (takes req/decoder inputs, drives PC and status).
//   master : the controlling side (drives req/decoder inputs, observes PC and status).
// Signals:
//   req, prog_sel          start request and program index
//   reljump_en, offset     relative jump enable and two's-complement offset
//   absjump_en, target     absolute jump enable and target address
//   halt, stall            decoded halt instruction, PC hold request
//   prog_ctr               instruction address to instr_ROM
//   run, done              state flags
//   timeout, err           end-of-run cause, valid while done
//   cycles                 RUN cycles of the current/last run
interface prog_sequencer_if #(
    parameter int unsigned D  = 12,
    parameter int unsigned P  = 3,
    parameter int unsigned CW = 16
);
    localparam int unsigned SW = (P > 1) ? $clog2(P) : 1;

    logic          req;
    logic [SW-1:0] prog_sel;
    logic          reljump_en;
    logic          absjump_en;
    logic [D-1:0]  target;
    logic [D-1:0]  offset;
    logic          halt;
    logic          stall;
    logic [D-1:0]  prog_ctr;
    logic          run;
    logic          done;
    logic          timeout;
    logic          err;
    logic [CW-1:0] cycles;

    modport slave (
        input  req, prog_sel, reljump_en, absjump_en, target, offset, halt, stall,
        output prog_ctr, run, done, timeout, err, cycles
    );

    modport master (
        output req, prog_sel, reljump_en, absjump_en, target, offset, halt, stall,
        input  prog_ctr, run, done, timeout, err, cycles
    );
endinterface

// File: rtl/prog_sequencer.sv
// Fetch/sequencing controller: owns the program counter, the req/done start
// handshake and selection of one of P programs by start-address bank.
// A run ends on halt, on the cycle watchdog, or on a PC wrap fault.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    prog_sequencer_if.slave (req, prog_sel, jumps, halt, stall in;
//          prog_ctr, run, done, timeout, err, cycles out)
// All outputs come straight from state registers.
module prog_sequencer #(
    parameter int unsigned D       = 12,
    parameter int unsigned P       = 3,
    parameter int unsigned SPAN    = 256,
    parameter int unsigned CW      = 16,
    parameter int unsigned MAX_CYC = 4000
) (
    input logic             clk,
    input logic             reset,
    prog_sequencer_if.slave bus
);
    localparam int unsigned SW = (P > 1) ? $clog2(P) : 1;

    localparam logic [SW:0]   PCount  = (SW + 1)'(P);
    localparam logic [D-1:0]  SpanD   = D'(SPAN);
    localparam logic [CW-1:0] CycLast = CW'(MAX_CYC - 1);
    localparam logic [CW-1:0] CycMax  = CW'(MAX_CYC);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          timeout_q, timeout_d;
    logic          err_q, err_d;

    logic          sel_ok;
    logic [D-1:0]  base_addr;
    logic [D+1:0]  rel_sum;
    logic [D:0]    inc_sum;
    logic          wrap;

    assign sel_ok    = {1'b0, bus.prog_sel} < PCount;
    assign base_addr = D'(bus.prog_sel) * SpanD;

    // Two guard bits: any nonzero guard bit means the signed sum left [0, 2^D-1].
    assign rel_sum = {2'b00, pc_q} + {{2{bus.offset[D-1]}}, bus.offset};
    assign inc_sum = {1'b0, pc_q} + {{D{1'b0}}, 1'b1};
    assign wrap    = bus.reljump_en ? (rel_sum[D+1:D] != 2'b00) : inc_sum[D];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cyc_d     = cyc_q;
        timeout_d = timeout_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    cyc_d     = '0;
                    timeout_d = 1'b0;
                    if (sel_ok) begin
                        state_d = StRun;
                        pc_d    = base_addr;
                        err_d   = 1'b0;
                    end else begin
                        state_d = StDone;
                        pc_d    = '0;
                        err_d   = 1'b1;
                    end
                end
            end

            StRun: begin
                if (bus.halt) begin
                    state_d = StDone;
                    cyc_d   = cyc_q + CW'(1);
                end else if (cyc_q == CycLast) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                    cyc_d     = CycMax;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                    if (bus.stall) begin
                        pc_d = pc_q;
                    end else if (bus.absjump_en) begin
                        pc_d = bus.target;
                    end else if (wrap) begin
                        // PC keeps its pre-wrap value for post-mortem.
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else if (bus.reljump_en) begin
                        pc_d = rel_sum[D-1:0];
                    end else begin
                        pc_d = inc_sum[D-1:0];
                    end
                end
            end

            StDone: begin
                if (!bus.req) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            cyc_q     <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cyc_q     <= cyc_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign bus.prog_ctr = pc_q;
    assign bus.run      = (state_q == StRun);
    assign bus.done     = (state_q == StDone);
    assign bus.timeout  = timeout_q;
    assign bus.err      = err_q;
    assign bus.cycles   = cyc_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized scoreboard bench for prog_sequencer. Each run is described as a
// list of per-cycle actions; a reference model walks that list and queues the
// expected PC trace and end-of-run record, and a monitor compares the DUT.
module tb_prog_sequencer;
    localparam int unsigned D    = 12;
    localparam int unsigned P    = 3;
    localparam int unsigned SPAN = 256;
    localparam int unsigned CW   = 16;
    localparam int unsigned MAXC = 48;
    localparam int          PCMAX = (1 << D) - 1;

    typedef struct {
        bit halt;
        bit stall;
        bit abs_en;
        bit rel_en;
        int target;
        int offset;
    } act_t;

    typedef struct {
        int pc;
        int cyc;
    } trace_t;

    typedef struct {
        int pc;
        int cyc;
        bit to;
        bit er;
    } end_t;

    logic clk;
    logic reset;

    prog_sequencer_if #(.D(D), .P(P), .CW(CW)) bus ();

    prog_sequencer #(
        .D      (D),
        .P      (P),
        .SPAN   (SPAN),
        .CW     (CW),
        .MAX_CYC(MAXC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    act_t   acts[$];
    trace_t trace_q[$];
    end_t   end_q[$];
    end_t   last;
    int     n_checks = 0;
    int     n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: walks the action list with plain integer arithmetic.
    task automatic model(input int sel, output int k);
        int pc;
        int cyc;
        int np;
        k = 0;
        if (sel >= P) begin
            end_q.push_back('{0, 0, 1'b0, 1'b1});
            return;
        end
        pc  = sel * SPAN;
        cyc = 0;
        trace_q.push_back('{pc, cyc});
        foreach (acts[i]) begin
            k = i + 1;
            if (acts[i].halt) begin
                end_q.push_back('{pc, cyc + 1, 1'b0, 1'b0});
                return;
            end
            if (cyc == MAXC - 1) begin
                end_q.push_back('{pc, MAXC, 1'b1, 1'b0});
                return;
            end
            cyc++;
            if (!acts[i].stall) begin
                if (acts[i].abs_en) begin
                    pc = acts[i].target;
                end else begin
                    np = acts[i].rel_en ? pc + acts[i].offset : pc + 1;
                    if (np < 0 || np > PCMAX) begin
                        end_q.push_back('{pc, cyc, 1'b0, 1'b1});
                        return;
                    end
                    pc = np;
                end
            end
            trace_q.push_back('{pc, cyc});
        end
    endtask

    task automatic push_act(input bit h, input bit s, input bit a, input bit r,
                            input int tgt, input int off);
        acts.push_back('{h, s, a, r, tgt, off});
    endtask

    task automatic push_incs(input int n);
        for (int i = 0; i < n; i++) push_act(0, 0, 0, 0, $urandom_range(0, PCMAX), 0);
    endtask

    task automatic gen_random();
        int r;
        int len;
        acts.delete();
        len = $urandom_range(1, 60);
        for (int i = 0; i < len - 1; i++) begin
            act_t a;
            r = $urandom_range(0, 99);
            a.halt   = 1'b0;
            a.stall  = 1'b0;
            a.abs_en = 1'b0;
            a.rel_en = 1'b0;
            a.target = ($urandom_range(0, 3) == 0) ? $urandom_range(PCMAX - 15, PCMAX)
                                                    : $urandom_range(0, PCMAX);
            a.offset = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4095)) - 2048
                                                    : int'($urandom_range(0, 40)) - 20;
            if (r < 2) begin
                a.halt   = 1'b1;
                a.stall  = 1'($urandom_range(0, 1));
                a.abs_en = 1'($urandom_range(0, 1));
            end else if (r < 14) begin
                a.stall  = 1'b1;
                a.abs_en = 1'($urandom_range(0, 1));
                a.rel_en = 1'($urandom_range(0, 1));
            end else if (r < 26) begin
                a.abs_en = 1'b1;
                a.rel_en = 1'($urandom_range(0, 1));
            end else if (r < 50) begin
                a.rel_en = 1'b1;
            end
            acts.push_back(a);
        end
        push_act(1, 0, 0, 0, 0, 0);
    endtask

    task automatic drive(input act_t a);
        bus.halt       = a.halt;
        bus.stall      = a.stall;
        bus.absjump_en = a.abs_en;
        bus.reljump_en = a.rel_en;
        bus.target     = D'(a.target);
        bus.offset     = D'(a.offset);
    endtask

    task automatic clear_inputs();
        bus.halt       = 1'b0;
        bus.stall      = 1'b0;
        bus.absjump_en = 1'b0;
        bus.reljump_en = 1'b0;
        bus.target     = '0;
        bus.offset     = '0;
    endtask

    // Entered and left at 2 time units after a rising edge.
    task automatic do_run(input int sel, input int hold);
        int k;
        model(sel, k);
        bus.req      = 1'b1;
        bus.prog_sel = 2'(sel);
        @(posedge clk); #2;
        for (int i = 0; i < k; i++) begin
            drive(acts[i]);
            @(posedge clk); #2;
        end
        clear_inputs();
        repeat (hold) begin
            @(posedge clk); #2;
        end
        bus.req = 1'b0;
        @(posedge clk); #2;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #2;
        end
    endtask

    // Monitor: compares every post-edge sample against the queued expectations.
    initial begin
        bit     prev_done;
        trace_t t;
        prev_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                prev_done = 1'b0;
            end else begin
                if (bus.run) begin
                    check("done_during_run", int'(bus.done), 0);
                    check("trace_pending", int'(trace_q.size() > 0), 1);
                    if (trace_q.size() > 0) begin
                        t = trace_q.pop_front();
                        check("run_prog_ctr", int'(bus.prog_ctr), t.pc);
                        check("run_cycles", int'(bus.cycles), t.cyc);
                    end
                end else if (bus.done) begin
                    if (!prev_done) begin
                        check("trace_drained_at_done", trace_q.size(), 0);
                        trace_q.delete();
                        check("end_pending", int'(end_q.size() > 0), 1);
                        if (end_q.size() > 0) last = end_q.pop_front();
                    end
                    check("done_prog_ctr", int'(bus.prog_ctr), last.pc);
                    check("done_cycles", int'(bus.cycles), last.cyc);
                    check("done_timeout", int'(bus.timeout), int'(last.to));
                    check("done_err", int'(bus.err), int'(last.er));
                end else begin
                    check("idle_cycles", int'(bus.cycles), last.cyc);
                    check("idle_timeout", int'(bus.timeout), int'(last.to));
                    check("idle_err", int'(bus.err), int'(last.er));
                end
                prev_done = bus.done;
            end
        end
    end

    initial begin
        last  = '{0, 0, 1'b0, 1'b0};
        reset = 1'b1;
        bus.req      = 1'b0;
        bus.prog_sel = '0;
        clear_inputs();
        #1 reset = 1'b0;
        #2;
        check("reset_prog_ctr", int'(bus.prog_ctr), 0);
        check("reset_run", int'(bus.run), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_timeout", int'(bus.timeout), 0);
        check("reset_err", int'(bus.err), 0);
        check("reset_cycles", int'(bus.cycles), 0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;

        // Program 1, five increments, then halt: ends at 261 after 6 cycles.
        acts.delete(); push_incs(5); push_act(1, 0, 0, 0, 0, 0);
        do_run(1, 2);

        // Absolute beats relative, negative relative, three stalls.
        acts.delete(); push_incs(10);
        push_act(0, 0, 1, 1, 40, 3);
        push_act(0, 0, 0, 1, 0, -2);
        push_act(0, 1, 0, 0, 0, 0); push_act(0, 1, 0, 1, 0, 5); push_act(0, 1, 1, 0, 7, 0);
        push_act(1, 0, 0, 0, 0, 0);
        do_run(0, 0);

        // Watchdog, with req held in DONE for 5 cycles.
        acts.delete(); push_incs(60); push_act(1, 0, 0, 0, 0, 0);
        do_run(2, 5);

        // Out-of-range program index.
        acts.delete();
        do_run(3, 1);

        // Forward wrap from 4095, and backward wrap from 0.
        acts.delete(); push_act(0, 0, 1, 0, PCMAX, 0); push_incs(1); push_act(1, 0, 0, 0, 0, 0);
        do_run(0, 0);
        acts.delete(); push_act(0, 0, 0, 1, 0, -1); push_act(1, 0, 0, 0, 0, 0);
        do_run(0, 1);

        // Reset in the middle of a run at prog_ctr 300.
        acts.delete(); push_incs(44); push_act(1, 0, 0, 0, 0, 0);
        begin
            int k;
            model(1, k);
            bus.req      = 1'b1;
            bus.prog_sel = 2'd1;
            @(posedge clk); #2;
            for (int i = 0; i < 44; i++) begin
                drive(acts[i]);
                @(posedge clk); #2;
            end
            check("pre_reset_prog_ctr", int'(bus.prog_ctr), 300);
            reset = 1'b0;
            #1;
            check("mid_reset_prog_ctr", int'(bus.prog_ctr), 0);
            check("mid_reset_run", int'(bus.run), 0);
            check("mid_reset_cycles", int'(bus.cycles), 0);
            trace_q.delete();
            end_q.delete();
            last = '{0, 0, 1'b0, 1'b0};
            clear_inputs();
            @(posedge clk); #2;
            reset = 1'b1;
        end
        acts.delete(); push_incs(3); push_act(1, 0, 0, 0, 0, 0);
        do_run(2, 0);

        for (int n = 0; n < 40; n++) begin
            gen_random();
            do_run($urandom_range(0, 3), $urandom_range(0, 4));
        end

        @(posedge clk); #2;
        check("queues_empty", trace_q.size() + end_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
